lii_in_unpack_buffer: RTL and testbench

//  Receive end of the LII packed-stream link. Accepts beats from one LII phy input

---
 rtl/lii_in_unpack_buffer.sv | 114 +++++++++++
 tb/tb_lii_in_unpack_buffer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_in_unpack_buffer.sv
// rtl/lii_in_unpack_buffer.sv - LII receive beat unpacker into NOUT per-lane AXIS FIFOs with kernel ce
// Optional destination filter and drop counter enabled by defining LII_DST_FILTER_EN.
module lii_in_unpack_buffer #(
  parameter int         NOUT  = 7,
  parameter int         LW    = 8,
  parameter int         PW    = 64,
  parameter int         DEPTH = 4,
  parameter logic [7:0] MY_ID = 8'd0
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic [PW-1:0]        lii_in_p0_tdata,
  input  logic                 lii_in_p0_tvalid,
  output logic                 lii_in_p0_tready,
  input  logic [7:0]           lii_in_p0_src,
  input  logic [7:0]           lii_in_p0_dst,
  output logic [NOUT*LW-1:0]   m_tdata,
  output logic [NOUT-1:0]      m_tvalid,
  input  logic [NOUT-1:0]      m_tready,
  output logic                 ce
`ifdef LII_DST_FILTER_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [NOUT-1:0] lane_space;
  logic            dst_miss;
  logic            beat_acc;
  logic            push;

`ifdef LII_DST_FILTER_EN
  assign dst_miss = (lii_in_p0_dst != MY_ID);
`else
  assign dst_miss = 1'b0;
`endif

  // Misrouted beats are swallowed even when lanes are full so they never stall the link.
  assign lii_in_p0_tready = ~arst & ((&lane_space) | dst_miss);
  assign beat_acc         = lii_in_p0_tvalid & lii_in_p0_tready;
  assign push             = beat_acc & ~dst_miss;

  // src never matters; dst, MY_ID and the unpacked low bits only matter in some builds.
  logic unused_inputs;
  assign unused_inputs = ^{lii_in_p0_src, lii_in_p0_dst, MY_ID, lii_in_p0_tdata};

  for (genvar i = 0; i < NOUT; i++) begin : g_lane
    logic [LW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [LW-1:0] last_word;
    logic [LW-1:0] din;
    logic          pop;

    assign din          = lii_in_p0_tdata[PW-1-i*LW -: LW];
    assign m_tvalid[i]  = (cnt != '0);
    assign lane_space[i] = (cnt < FULL);
    assign pop          = m_tvalid[i] & m_tready[i];
    // An empty lane keeps presenting the word it last handed out.
    assign m_tdata[i*LW +: LW] = m_tvalid[i] ? mem[rd_ptr] : last_word;

    always_ff @(posedge aclk) begin
      if (push) begin
        mem[wr_ptr] <= din;
      end
    end

    always_ff @(posedge aclk) begin
      if (arst) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cnt       <= '0;
        last_word <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          last_word <= mem[rd_ptr];
        end
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      ce <= 1'b0;
    end else begin
      ce <= (&m_tvalid) & (&m_tready);
    end
  end

`ifdef LII_DST_FILTER_EN
  always_ff @(posedge aclk) begin
    if (arst) begin
      drop_cnt <= '0;
    end else if (beat_acc && dst_miss && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lii_in_unpack_buffer.sv
// tb/tb_lii_in_unpack_buffer.sv - randomized queue-model bench for lii_in_unpack_buffer
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_lii_in_unpack_buffer;
  localparam int NOUT = 7;
  localparam int LW = 8;
  localparam int PW = 64;
  localparam int DEPTH = 4;
  localparam logic [7:0] MY_ID = 8'd5;
`ifdef LII_DST_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic                 aclk = 1'b0;
  logic                 arst;
  logic [PW-1:0]        lii_in_p0_tdata;
  logic                 lii_in_p0_tvalid;
  logic                 lii_in_p0_tready;
  logic [7:0]           lii_in_p0_src;
  logic [7:0]           lii_in_p0_dst;
  logic [NOUT*LW-1:0]   m_tdata;
  logic [NOUT-1:0]      m_tvalid;
  logic [NOUT-1:0]      m_tready;
  logic                 ce;
`ifdef LII_DST_FILTER_EN
  logic [15:0]          drop_cnt;
`endif

  always #5 aclk = ~aclk;

  lii_in_unpack_buffer #(
    .NOUT(NOUT), .LW(LW), .PW(PW), .DEPTH(DEPTH), .MY_ID(MY_ID)
  ) dut (
    .aclk(aclk),
    .arst(arst),
    .lii_in_p0_tdata(lii_in_p0_tdata),
    .lii_in_p0_tvalid(lii_in_p0_tvalid),
    .lii_in_p0_tready(lii_in_p0_tready),
    .lii_in_p0_src(lii_in_p0_src),
    .lii_in_p0_dst(lii_in_p0_dst),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .ce(ce)
`ifdef LII_DST_FILTER_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  // Reference model: one queue per lane plus the last word each lane handed out.
  logic [LW-1:0] q [NOUT][$];
  logic [LW-1:0] last_w [NOUT];
  logic          exp_ce;
  logic [15:0]   exp_drop;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [LW-1:0] lane_of(input logic [PW-1:0] d, input int i);
    return LW'(d >> (PW - LW * (i + 1)));
  endfunction

  function automatic logic model_tready();
    if (arst) return 1'b0;
    if (FILT && lii_in_p0_dst != MY_ID) return 1'b1;
    for (int i = 0; i < NOUT; i++) if (q[i].size() >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [LW-1:0] exp_lane(input int i);
    return (q[i].size() > 0) ? q[i][0] : last_w[i];
  endfunction

  task automatic tick();
    logic acc, all_v, all_r;
    @(posedge aclk);
    if (arst) begin
      for (int i = 0; i < NOUT; i++) begin
        q[i].delete();
        last_w[i] = '0;
      end
      exp_ce   = 1'b0;
      exp_drop = '0;
    end else begin
      acc   = lii_in_p0_tvalid && model_tready();
      all_v = 1'b1;
      all_r = 1'b1;
      for (int i = 0; i < NOUT; i++) begin
        if (q[i].size() == 0) all_v = 1'b0;
        if (!m_tready[i]) all_r = 1'b0;
      end
      exp_ce = all_v && all_r;
      for (int i = 0; i < NOUT; i++)
        if (q[i].size() > 0 && m_tready[i]) last_w[i] = q[i].pop_front();
      if (acc) begin
        if (!FILT || lii_in_p0_dst == MY_ID) begin
          for (int i = 0; i < NOUT; i++) q[i].push_back(lane_of(lii_in_p0_tdata, i));
        end else if (exp_drop != 16'hFFFF) begin
          exp_drop = exp_drop + 16'd1;
        end
      end
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (3) begin
      tick();
      #1;
      checks++;
      if (lii_in_p0_tready !== 1'b0) begin
        errors++;
        $display("FAIL reset_tready_low: got %b expected 0", lii_in_p0_tready);
      end
    end
    arst = 1'b0;
    #1;
    checks++;
    if (lii_in_p0_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready_release: got %b expected 1", lii_in_p0_tready);
    end
    checks++;
    if (m_tvalid !== '0 || ce !== 1'b0 || m_tdata !== '0) begin
      errors++;
      $display("FAIL reset_idle: tvalid %h ce %b tdata %h expected all zero", m_tvalid, ce, m_tdata);
    end
    tick();
  endtask

  task automatic test_single_beat();
    logic [NOUT*LW-1:0] exp_word;
    exp_word = 56'h07060504030201;
    m_tready = '1;
    lii_in_p0_tdata  = 64'h0102030405060700;
    lii_in_p0_tvalid = 1'b1;
    tick();
    lii_in_p0_tvalid = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 7'h7f || m_tdata !== exp_word) begin
      errors++;
      $display("FAIL single_data: tvalid %h tdata %h expected 7f %h", m_tvalid, m_tdata, exp_word);
    end
    checks++;
    if (ce !== 1'b0) begin
      errors++;
      $display("FAIL single_ce_early: got %b expected 0", ce);
    end
    tick();
    #1;
    checks++;
    if (ce !== 1'b1 || m_tvalid !== '0) begin
      errors++;
      $display("FAIL single_ce: ce %b tvalid %h expected 1 00", ce, m_tvalid);
    end
    checks++;
    if (m_tdata !== exp_word) begin
      errors++;
      $display("FAIL single_hold_last: got %h expected %h", m_tdata, exp_word);
    end
    tick();
    #1;
    checks++;
    if (ce !== 1'b0) begin
      errors++;
      $display("FAIL single_ce_drop: got %b expected 0", ce);
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] beats [5];
    logic acc;
    int k, j;
    for (int b = 0; b < 5; b++) beats[b] = {$urandom, $urandom};
    m_tready = 7'h77;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      lii_in_p0_tdata  = beats[k];
      lii_in_p0_tvalid = 1'b1;
      #1;
      checks++;
      if (lii_in_p0_tready !== model_tready() || (k == 4 && lii_in_p0_tready !== 1'b0)) begin
        errors++;
        $display("FAIL bp_tready: cycle %0d got %b expected %b", c, lii_in_p0_tready, model_tready());
      end
      acc = model_tready();
      tick();
      if (acc) k++;
    end
    m_tready = '1;
    j = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) lii_in_p0_tvalid = 1'b0;
      #1;
      if (c < 2) begin
        checks++;
        if (lii_in_p0_tready !== (c == 1)) begin
          errors++;
          $display("FAIL bp_release_tready: cycle %0d got %b expected %b", c, lii_in_p0_tready, c == 1);
        end
      end
      if (m_tvalid[3] && j < 5) begin
        checks++;
        if (m_tdata[3*LW +: LW] !== lane_of(beats[j], 3)) begin
          errors++;
          $display("FAIL bp_lane3_order: word %0d got %h expected %h", j, m_tdata[3*LW +: LW], lane_of(beats[j], 3));
        end
        j++;
      end
      tick();
    end
    #1;
    checks++;
    if (j != 5 || m_tvalid !== '0) begin
      errors++;
      $display("FAIL bp_count: lane3 words %0d tvalid %h expected 5 00", j, m_tvalid);
    end
  endtask

  task automatic test_full_pop();
    logic [PW-1:0] beats [4];
    for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
    m_tready = 7'h7e;
    lii_in_p0_tvalid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      lii_in_p0_tdata = beats[b];
      tick();
    end
    lii_in_p0_tdata = beats[3];
    m_tready = '1;
    #1;
    checks++;
    if (lii_in_p0_tready !== 1'b1 || m_tdata[LW-1:0] !== lane_of(beats[0], 0)) begin
      errors++;
      $display("FAIL fullpop_setup: tready %b lane0 %h expected 1 %h", lii_in_p0_tready, m_tdata[LW-1:0], lane_of(beats[0], 0));
    end
    tick();
    lii_in_p0_tvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (m_tvalid[0] !== (c < 3) || (c < 3 && m_tdata[LW-1:0] !== lane_of(beats[c+1], 0))) begin
        errors++;
        $display("FAIL fullpop_drain: step %0d valid %b data %h expected %b %h", c, m_tvalid[0], m_tdata[LW-1:0], c < 3, lane_of(beats[(c < 3) ? c+1 : 3], 0));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    m_tready = '0;
    lii_in_p0_tvalid = 1'b1;
    repeat (2) begin
      lii_in_p0_tdata = {$urandom, $urandom};
      tick();
    end
    lii_in_p0_tvalid = 1'b0;
    arst = 1'b1;
    tick();
    arst = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== '0 || m_tdata !== '0 || lii_in_p0_tready !== 1'b1 || ce !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flush: tvalid %h tdata %h tready %b ce %b expected 00 0 1 0", m_tvalid, m_tdata, lii_in_p0_tready, ce);
    end
    m_tready = '1;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      checks++;
      if (m_tvalid !== '0) begin
        errors++;
        $display("FAIL midreset_stale: cycle %0d tvalid %h expected 00", c, m_tvalid);
      end
    end
  endtask

  task automatic test_filter();
    logic [7:0] dsts [3];
    int delivered;
    dsts[0] = 8'd5;
    dsts[1] = 8'd9;
    dsts[2] = 8'd5;
    delivered = 0;
    m_tready = '1;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        lii_in_p0_tvalid = 1'b1;
        lii_in_p0_dst    = dsts[c];
        lii_in_p0_tdata  = {$urandom, $urandom};
      end else begin
        lii_in_p0_tvalid = 1'b0;
        lii_in_p0_dst    = MY_ID;
      end
      #1;
      if (m_tvalid[0]) delivered++;
      tick();
    end
    checks++;
    if (delivered != (FILT ? 2 : 3)) begin
      errors++;
      $display("FAIL filter_delivered: got %0d expected %0d", delivered, FILT ? 2 : 3);
    end
`ifdef LII_DST_FILTER_EN
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL filter_drop_cnt: got %0d expected 1", drop_cnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      arst             = ($urandom_range(0, 99) == 0);
      lii_in_p0_tvalid = ($urandom_range(0, 3) != 0);
      lii_in_p0_tdata  = {$urandom, $urandom};
      lii_in_p0_src    = 8'($urandom);
      lii_in_p0_dst    = ($urandom_range(0, 3) == 0) ? 8'd9 : MY_ID;
      m_tready         = ($urandom_range(0, 2) == 0) ? '1 : NOUT'($urandom);
      #1;
      checks++;
      if (lii_in_p0_tready !== model_tready()) begin
        errors++;
        $display("FAIL rand_tready: cycle %0d got %b expected %b", c, lii_in_p0_tready, model_tready());
      end
      for (int i = 0; i < NOUT; i++) begin
        checks++;
        if (m_tvalid[i] !== (q[i].size() > 0) || m_tdata[i*LW +: LW] !== exp_lane(i)) begin
          errors++;
          $display("FAIL rand_lane: cycle %0d lane %0d valid %b data %h expected %b %h", c, i, m_tvalid[i], m_tdata[i*LW +: LW], q[i].size() > 0, exp_lane(i));
        end
      end
      checks++;
      if (ce !== exp_ce) begin
        errors++;
        $display("FAIL rand_ce: cycle %0d got %b expected %b", c, ce, exp_ce);
      end
`ifdef LII_DST_FILTER_EN
      checks++;
      if (drop_cnt !== exp_drop) begin
        errors++;
        $display("FAIL rand_drop_cnt: cycle %0d got %0d expected %0d", c, drop_cnt, exp_drop);
      end
`endif
      tick();
    end
    arst = 1'b0;
    lii_in_p0_tvalid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NOUT; i++) last_w[i] = '0;
    exp_ce           = 1'b0;
    exp_drop         = '0;
    arst             = 1'b1;
    lii_in_p0_tdata  = '0;
    lii_in_p0_tvalid = 1'b0;
    lii_in_p0_src    = 8'd0;
    lii_in_p0_dst    = MY_ID;
    m_tready         = '0;
    @(negedge aclk);
    test_reset();
    test_single_beat();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_filter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
